operand_stack: RTL and testbench

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/stack_pkg.sv | 27 ++
 rtl/stack_mem.sv | 26 ++
 rtl/operand_stack.sv | 148 ++++++++++++++
 tb/tb_operand_stack.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared defaults and operation decode for the operand stack.
package stack_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 16;
   localparam int unsigned PTR_W_DEF  = 4;

   typedef enum logic [1:0] {
      NOP     = 2'd0,
      PUSH    = 2'd1,
      POP     = 2'd2,
      REPLACE = 2'd3
   } stack_op_e;

   // Push and pop together on an empty stack degenerates to a plain push.
   function automatic stack_op_e decode_op(input logic push,
                                           input logic pop,
                                           input logic is_empty);
      stack_op_e op;
      if (push && pop)  op = is_empty ? PUSH : REPLACE;
      else if (push)    op = PUSH;
      else if (pop)     op = POP;
      else              op = NOP;
      return op;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// Storage for the entries below top of stack: one synchronous write port,
// one asynchronous read port, contents not reset.
module stack_mem #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ENTRIES = 15,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < ENTRIES)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (32'(raddr) < ENTRIES) ? mem[raddr] : '0;

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack with a registered top-of-stack word.
// Define STACK_GUARD_EN to block push-when-full / pop-when-empty and flag them.
module operand_stack
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned PTR_W  = PTR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_to_push,
   output logic [DATA_W-1:0] data_from_stack,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] SP_ONE    = PTR_W'(1);
   localparam logic [PTR_W-1:0] SP_LAST   = PTR_W'(DEPTH-2);

   // sp tracks array occupancy, i.e. count-1 once the stack is non-empty.
   logic [PTR_W-1:0]  sp_q, sp_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [DATA_W-1:0] tos_q, tos_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              mem_we;
   logic [PTR_W-1:0]  mem_waddr;
   logic [PTR_W-1:0]  mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   stack_op_e         op;

   stack_mem #(
      .DATA_W  (DATA_W),
      .ENTRIES (DEPTH-1),
      .ADDR_W  (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (tos_q),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_comb begin
      sp_d      = sp_q;
      count_d   = count_q;
      tos_d     = tos_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_we    = 1'b0;
      mem_waddr = sp_q;
      mem_raddr = (count_q == '0) ? SP_LAST : (sp_q - SP_ONE);
      op        = decode_op(push, pop, count_q == '0);

      if (clr) begin
         sp_d    = '0;
         count_d = '0;
         tos_d   = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         case (op)
            PUSH: begin
               if (count_q == DEPTH_C) begin
`ifdef STACK_GUARD_EN
                  ovf_d = 1'b1;
`else
                  // Wrap: old top overwrites the oldest slot, count wraps to 1.
                  mem_we    = 1'b1;
                  mem_waddr = '0;
                  tos_d     = data_to_push;
                  count_d   = CNT_ONE;
                  sp_d      = '0;
`endif
               end else begin
                  if (count_q != '0) begin
                     mem_we = 1'b1;
                     sp_d   = sp_q + SP_ONE;
                  end
                  tos_d   = data_to_push;
                  count_d = count_q + CNT_ONE;
               end
            end
            POP: begin
               if (count_q == '0) begin
`ifdef STACK_GUARD_EN
                  unf_d = 1'b1;
`else
                  tos_d   = mem_rdata;
                  count_d = DEPTH_C - CNT_ONE;
                  sp_d    = SP_LAST;
`endif
               end else if (count_q == CNT_ONE) begin
                  tos_d   = '0;
                  count_d = '0;
                  sp_d    = '0;
               end else begin
                  tos_d   = mem_rdata;
                  count_d = count_q - CNT_ONE;
                  sp_d    = sp_q - SP_ONE;
               end
            end
            REPLACE: tos_d = data_to_push;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q    <= '0;
         count_q <= '0;
         tos_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         tos_q   <= tos_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign data_from_stack = tos_q;
   assign count           = count_q;
   assign empty           = (count_q == '0);
   assign full            = (count_q == DEPTH_C);
`ifdef STACK_GUARD_EN
   assign overflow        = ovf_q;
   assign underflow       = unf_q;
`else
   assign overflow        = 1'b0;
   assign underflow       = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack (both STACK_GUARD_EN builds).
module tb_operand_stack;

   logic       clk;
   logic       reset;
   logic       clr;
   logic       push;
   logic       pop;
   logic [7:0] data_to_push;
   logic [7:0] data_from_stack;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       overflow;
   logic       underflow;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   operand_stack #(
      .DATA_W (8),
      .DEPTH  (16),
      .PTR_W  (4)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .clr             (clr),
      .push            (push),
      .pop             (pop),
      .data_to_push    (data_to_push),
      .data_from_stack (data_from_stack),
      .count           (count),
      .empty           (empty),
      .full            (full),
      .overflow        (overflow),
      .underflow       (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of strobes, sample 1ns after the edge.
   task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
      push = p; pop = q; data_to_push = d; clr = c;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr = 1'b0; data_to_push = '0;
   endtask

   initial begin
      reset = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; data_to_push = '0;
      #3;
      check("rst_count", 32'(count), 0);
      check("rst_top",   32'(data_from_stack), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full",  32'(full), 0);
      check("rst_ovf",   32'(overflow), 0);
      check("rst_unf",   32'(underflow), 0);
      #9;
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic push / pop ordering
      step(1, 0, 8'h11, 0);
      step(1, 0, 8'h22, 0);
      step(1, 0, 8'h33, 0);
      check("p3_top",   32'(data_from_stack), 32'h33);
      check("p3_count", 32'(count), 3);
      step(0, 1, 8'h00, 0);
      check("pop1_top", 32'(data_from_stack), 32'h22);
      step(0, 1, 8'h00, 0);
      check("pop2_top",   32'(data_from_stack), 32'h11);
      check("pop2_count", 32'(count), 1);
      step(0, 1, 8'h00, 0);
      check("pop3_top",   32'(data_from_stack), 0);
      check("pop3_empty", 32'(empty), 1);
      check("pop3_count", 32'(count), 0);

      // Push and pop together replaces the top
      step(1, 0, 8'h05, 0);
      step(1, 1, 8'h07, 0);
      check("repl_top",   32'(data_from_stack), 32'h07);
      check("repl_count", 32'(count), 1);
      check("repl_empty", 32'(empty), 0);
      step(0, 1, 8'h00, 0);
      check("repl_pop_top", 32'(data_from_stack), 0);
      check("repl_pop_cnt", 32'(count), 0);

      // Fill to capacity
      for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0);
      check("fill_full",  32'(full), 1);
      check("fill_top",   32'(data_from_stack), 32'h0F);
      check("fill_count", 32'(count), 16);
      step(1, 0, 8'hAA, 0);
`ifdef STACK_GUARD_EN
      check("ovf_top",   32'(data_from_stack), 32'h0F);
      check("ovf_count", 32'(count), 16);
      check("ovf_flag",  32'(overflow), 1);
      step(0, 1, 8'h00, 0);
      check("ovf_pop_top", 32'(data_from_stack), 32'h0E);
      check("ovf_pop_cnt", 32'(count), 15);
      check("ovf_sticky",  32'(overflow), 1);
      step(0, 0, 8'h00, 1);
      check("ovf_clr",     32'(overflow), 0);
      check("ovf_clr_cnt", 32'(count), 0);
      step(0, 1, 8'h00, 0);
      check("unf_flag",  32'(underflow), 1);
      check("unf_count", 32'(count), 0);
      check("unf_empty", 32'(empty), 1);
      step(0, 0, 8'h00, 1);
      check("unf_clr", 32'(underflow), 0);
`else
      check("wrap_top",   32'(data_from_stack), 32'hAA);
      check("wrap_count", 32'(count), 1);
      check("wrap_ovf",   32'(overflow), 0);
      step(0, 1, 8'h00, 0);
      check("wrap_pop_top", 32'(data_from_stack), 0);
      check("wrap_pop_cnt", 32'(count), 0);
      step(0, 1, 8'h00, 0);
      check("uwrap_top",   32'(data_from_stack), 32'h0E);
      check("uwrap_count", 32'(count), 15);
      check("uwrap_unf",   32'(underflow), 0);
      step(0, 0, 8'h00, 1);
      check("uwrap_clr_cnt", 32'(count), 0);
`endif

      // Asynchronous reset mid-sequence discards an in-flight push
      for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 0);
      check("pre_rst_count", 32'(count), 5);
      @(negedge clk);
      push = 1'b1; data_to_push = 8'h66;
      #2;
      reset = 1'b0;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_top",   32'(data_from_stack), 0);
      check("arst_empty", 32'(empty), 1);
      check("arst_full",  32'(full), 0);
      @(posedge clk); #1;
      check("arst_hold_cnt", 32'(count), 0);
      push = 1'b0; data_to_push = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("arst_rel_cnt", 32'(count), 0);

      // Idle hold, then clr wins over push
      step(1, 0, 8'hA1, 0);
      step(1, 0, 8'hA2, 0);
      step(1, 0, 8'hA3, 0);
      step(0, 0, 8'h00, 0);
      check("idle_count", 32'(count), 3);
      check("idle_top",   32'(data_from_stack), 32'hA3);
      step(1, 0, 8'h99, 1);
      check("clrpush_count", 32'(count), 0);
      check("clrpush_top",   32'(data_from_stack), 0);
      check("clrpush_empty", 32'(empty), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
